// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard for the 4-register pipelined CPU.
// Follows each writing instruction's destination through EX/MEM/WB. From that it drives
// the ID stage's forward selects, the load-use stall, and a per-register pending-write mask.
module dest_scoreboard #(
    parameter int unsigned NREG  = 4,
    parameter int unsigned DEPTH = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            issue_valid,
    input  logic            issue_regwrite,
    input  logic            issue_memread,
    input  logic [1:0]      issue_rd,
    input  logic            flush,
    input  logic [1:0]      rs,
    input  logic [1:0]      rt,
    input  logic            use_rs,
    input  logic            use_rt,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            stall,
    output logic [NREG-1:0] pending_mask,
    output logic            wb_valid,
    output logic [1:0]      wb_rd
);

    // A counter must hold every in-flight write to one register (0..DEPTH).
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [CW-1:0] cnt_t;

    logic       ex_v_q, mem_v_q, wb_v_q;
    logic [1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic       ex_ld_q, mem_ld_q, wb_ld_q;
    cnt_t       cnt_q [NREG];
    cnt_t       cnt_d [NREG];
    logic       accept;

    // Youngest matching in-flight writer wins; an unused operand never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic       use_op,
        input logic [1:0] idx,
        input logic       exv,
        input logic [1:0] exr,
        input logic       memv,
        input logic [1:0] memr,
        input logic       wbv,
        input logic [1:0] wbr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_op) begin
            if (exv && exr == idx) begin
                sel = 2'b11;
            end else if (memv && memr == idx) begin
                sel = 2'b10;
            end else if (wbv && wbr == idx) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Load-use hazard: the load in EX cannot forward its data until it reaches MEM.
    always_comb begin
        stall = ex_v_q & ex_ld_q &
                ((use_rs & (ex_rd_q == rs)) | (use_rt & (ex_rd_q == rt)));
    end

    // A stalled or flushed ID instruction turns into a bubble in EX.
    always_comb begin
        accept = issue_valid & issue_regwrite & ~flush & ~stall;
    end

    // Operand forward selects seen by the ID stage.
    always_comb begin
        fwd_a = fwd_sel(use_rs, rs, ex_v_q, ex_rd_q, mem_v_q, mem_rd_q, wb_v_q, wb_rd_q);
        fwd_b = fwd_sel(use_rt, rt, ex_v_q, ex_rd_q, mem_v_q, mem_rd_q, wb_v_q, wb_rd_q);
    end

    // Pending counters: +1 on an accepted issue, -1 on a WB retire, no change if both hit.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (accept && issue_rd == 2'(r) && !(wb_v_q && wb_rd_q == 2'(r))) begin
                cnt_d[r] = cnt_q[r] + cnt_t'(1);
            end else if (wb_v_q && wb_rd_q == 2'(r) && !(accept && issue_rd == 2'(r))) begin
                // Saturates at zero; an unmatched retire should never happen.
                cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - cnt_t'(1);
            end
        end
    end

    // Pending mask and WB view come straight from registers.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
        end
        wb_valid = wb_v_q;
        wb_rd    = wb_rd_q;
    end

    // Slot shift register; the shift is unconditional, so tags advance with the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= 2'b00;
            ex_ld_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= 2'b00;
            mem_ld_q <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= 2'b00;
            wb_ld_q  <= 1'b0;
        end else begin
            ex_v_q   <= accept;
            ex_rd_q  <= accept ? issue_rd : 2'b00;
            ex_ld_q  <= accept & issue_memread;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_ld_q <= ex_ld_q;
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
            wb_ld_q  <= mem_ld_q;
        end
    end

    // Pending counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // The load flag leaves the WB slot unread; keep it only so the slot contents are
    // complete when traced.
    logic unused_wb_ld;
    always_comb begin
        unused_wb_ld = wb_ld_q;
    end

endmodule

// File: tb/tb_dest_scoreboard.sv
// Self-checking bench for dest_scoreboard: directed scenarios plus a randomized run
// compared against an age-based model of in-flight writes.
module tb_dest_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       issue_valid, issue_regwrite, issue_memread, flush;
    logic [1:0] issue_rd, rs, rt;
    logic       use_rs, use_rt;
    logic [1:0] fwd_a, fwd_b;
    logic       stall;
    logic [3:0] pending_mask;
    logic       wb_valid;
    logic [1:0] wb_rd;

    int n_cmp = 0;
    int n_bad = 0;

    dest_scoreboard #(.NREG(4), .DEPTH(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_memread  (issue_memread),
        .issue_rd       (issue_rd),
        .flush          (flush),
        .rs             (rs),
        .rt             (rt),
        .use_rs         (use_rs),
        .use_rt         (use_rt),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .stall          (stall),
        .pending_mask   (pending_mask),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        issue_valid = 0; issue_regwrite = 0; issue_memread = 0; issue_rd = 0;
        flush = 0; rs = 0; rt = 0; use_rs = 0; use_rt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] rd, input logic ld);
        issue_valid = 1; issue_regwrite = 1; issue_memread = ld; issue_rd = rd;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 0;
        step();
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        issue(2'd1, 0); step();
        issue(2'd2, 0); step();
        issue(2'd3, 1); step();
        idle_inputs();
        rt = 3; use_rt = 1; rs = 2; use_rs = 1;
        #1;
        n_cmp++; if (pending_mask !== 4'b1110) begin n_bad++;
            $display("FAIL reset_pre_mask got %b want %b", pending_mask, 4'b1110); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++;
            $display("FAIL reset_pre_stall got %b want %b", stall, 1'b1); end
        reset_n = 0;
        #1;
        n_cmp++; if (pending_mask !== 4'b0000) begin n_bad++;
            $display("FAIL reset_mask got %b want %b", pending_mask, 4'b0000); end
        n_cmp++; if ({fwd_a, fwd_b, stall, wb_valid, wb_rd} !== 8'h00) begin n_bad++;
            $display("FAIL reset_outs got fa=%b fb=%b st=%b wv=%b wr=%b want all 0",
                     fwd_a, fwd_b, stall, wb_valid, wb_rd); end
        #2;
        reset_n = 1;
        step();
        n_cmp++; if ({pending_mask, wb_valid, fwd_a, fwd_b} !== 9'h0) begin n_bad++;
            $display("FAIL reset_fresh got pm=%b wv=%b fa=%b fb=%b want 0",
                     pending_mask, wb_valid, fwd_a, fwd_b); end
    endtask

    task automatic test_fwd_chain();
        logic [1:0] exp_f [4];
        logic [3:0] exp_m [4];
        exp_f[0] = 2'b11; exp_f[1] = 2'b10; exp_f[2] = 2'b01; exp_f[3] = 2'b00;
        exp_m[0] = 4'b0100; exp_m[1] = 4'b0100; exp_m[2] = 4'b0100; exp_m[3] = 4'b0000;
        apply_reset();
        issue(2'd2, 0); step();
        idle_inputs(); rs = 2; use_rs = 1;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) step();
            #1;
            n_cmp++; if (fwd_a !== exp_f[c]) begin n_bad++;
                $display("FAIL chain_fwd_a[%0d] got %b want %b", c, fwd_a, exp_f[c]); end
            n_cmp++; if (pending_mask !== exp_m[c]) begin n_bad++;
                $display("FAIL chain_mask[%0d] got %b want %b", c, pending_mask, exp_m[c]); end
            n_cmp++; if ({wb_valid, wb_rd} !== ((c == 2) ? 3'b110 : 3'b000)) begin n_bad++;
                $display("FAIL chain_wb[%0d] got %b/%b", c, wb_valid, wb_rd); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        issue(2'd1, 0); step();
        step();
        idle_inputs(); rs = 1; use_rs = 1;
        #1;
        n_cmp++; if (fwd_a !== 2'b11) begin n_bad++;
            $display("FAIL b2b_fwd_a got %b want %b", fwd_a, 2'b11); end
        step(); step();
        n_cmp++; if (pending_mask !== 4'b0010) begin n_bad++;
            $display("FAIL b2b_mask_one_left got %b want %b", pending_mask, 4'b0010); end
        step();
        n_cmp++; if (pending_mask !== 4'b0000) begin n_bad++;
            $display("FAIL b2b_mask_done got %b want %b", pending_mask, 4'b0000); end
    endtask

    task automatic test_load_use();
        apply_reset();
        issue(2'd3, 1); step();
        issue(2'd0, 0); rt = 3; use_rt = 1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++;
            $display("FAIL lu_stall got %b want %b", stall, 1'b1); end
        step();
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL lu_stall_clear got %b want %b", stall, 1'b0); end
        n_cmp++; if (fwd_b !== 2'b10) begin n_bad++;
            $display("FAIL lu_fwd_b got %b want %b", fwd_b, 2'b10); end
        n_cmp++; if (pending_mask !== 4'b1000) begin n_bad++;
            $display("FAIL lu_bubble_mask got %b want %b", pending_mask, 4'b1000); end
        step();
        n_cmp++; if (pending_mask !== 4'b1001) begin n_bad++;
            $display("FAIL lu_reissue_mask got %b want %b", pending_mask, 4'b1001); end
    endtask

    task automatic test_flush();
        apply_reset();
        issue(2'd0, 0); flush = 1; step();
        idle_inputs(); rs = 0; rt = 0; use_rs = 1; use_rt = 1;
        #1;
        n_cmp++; if ({pending_mask, fwd_a, fwd_b} !== 8'h00) begin n_bad++;
            $display("FAIL flush got pm=%b fa=%b fb=%b want 0", pending_mask, fwd_a, fwd_b); end
        step(); step();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++;
            $display("FAIL flush_wb got %b want %b", wb_valid, 1'b0); end
    endtask

    task automatic test_retire_issue();
        apply_reset();
        issue(2'd1, 0); step();
        idle_inputs(); step(); step();
        issue(2'd1, 0);
        #1;
        n_cmp++; if ({wb_valid, wb_rd, pending_mask} !== 7'b1010010) begin n_bad++;
            $display("FAIL ri_before got wv=%b wr=%b pm=%b", wb_valid, wb_rd, pending_mask); end
        for (int c = 0; c < 4; c++) begin
            step();
            idle_inputs();
            n_cmp++; if (pending_mask !== ((c < 3) ? 4'b0010 : 4'b0000)) begin n_bad++;
                $display("FAIL ri_mask[%0d] got %b", c, pending_mask); end
        end
    endtask

    typedef struct {
        logic [1:0] rd;
        logic       ld;
        int         born;
    } rec_t;

    // Model: each accepted write is remembered with the cycle it entered EX; its age
    // decides which stage holds it (0 EX, 1 MEM, 2 WB, 3+ retired).
    task automatic test_random();
        rec_t       q[$];
        int         cyc;
        logic [1:0] ea, eb;
        int         ba, bb, age;
        logic       es, acc, ewv;
        logic [1:0] ewr;
        logic [3:0] em;
        apply_reset();
        cyc = 0;
        for (int n = 0; n < 600; n++) begin
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_regwrite = ($urandom_range(0, 3) != 0);
            issue_memread  = ($urandom_range(0, 2) == 0);
            issue_rd       = 2'($urandom_range(0, 3));
            flush          = ($urandom_range(0, 7) == 0);
            rs             = 2'($urandom_range(0, 3));
            rt             = 2'($urandom_range(0, 3));
            use_rs         = 1'($urandom_range(0, 1));
            use_rt         = 1'($urandom_range(0, 1));
            #1;
            ea = 0; eb = 0; ba = 99; bb = 99; es = 0; em = 0; ewv = 0; ewr = 0;
            foreach (q[i]) begin
                age = cyc - q[i].born;
                if (age <= 2) begin
                    em[q[i].rd] = 1'b1;
                    if (age == 2) begin ewv = 1; ewr = q[i].rd; end
                    if (use_rs && q[i].rd == rs && age < ba) begin ba = age; ea = 2'(3 - age); end
                    if (use_rt && q[i].rd == rt && age < bb) begin bb = age; eb = 2'(3 - age); end
                    if (age == 0 && q[i].ld &&
                        ((use_rs && q[i].rd == rs) || (use_rt && q[i].rd == rt))) es = 1;
                end
            end
            n_cmp++; if (fwd_a !== ea) begin n_bad++;
                $display("FAIL rnd_fwd_a cyc %0d got %b want %b", n, fwd_a, ea); end
            n_cmp++; if (fwd_b !== eb) begin n_bad++;
                $display("FAIL rnd_fwd_b cyc %0d got %b want %b", n, fwd_b, eb); end
            n_cmp++; if (stall !== es) begin n_bad++;
                $display("FAIL rnd_stall cyc %0d got %b want %b", n, stall, es); end
            n_cmp++; if (pending_mask !== em) begin n_bad++;
                $display("FAIL rnd_mask cyc %0d got %b want %b", n, pending_mask, em); end
            n_cmp++; if (wb_valid !== ewv || (ewv && wb_rd !== ewr)) begin n_bad++;
                $display("FAIL rnd_wb cyc %0d got %b/%b want %b/%b", n, wb_valid, wb_rd, ewv, ewr); end
            acc = issue_valid && issue_regwrite && !flush && !es;
            @(posedge clk);
            cyc++;
            if (acc) q.push_back('{rd: issue_rd, ld: issue_memread, born: cyc});
            while (q.size() > 0 && cyc - q[0].born > 2) void'(q.pop_front());
            #1;
        end
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        #12;
        test_reset();
        test_fwd_chain();
        test_back_to_back();
        test_load_use();
        test_flush();
        test_retire_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
